// File: rtl/aes_sched_pkg.sv
// Shared widths and state encoding for the aes_sched scheduler.
// The state enum is the single source of the FSM encoding used by the top.
package aes_sched_pkg;

    localparam int AES_W = 128;
    localparam int TO_W  = 10;
    localparam int RST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CRST = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/aes_sched_rr_arb2.sv
// Combinational two-way round-robin arbiter.
// On contention the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
        if (valid != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/aes_sched.sv
// Two-requester scheduler sharing one iterative AES core, with a
// restart pulse per job and a watchdog that turns a hung core into an error.
//
// state | meaning
// IDLE  | core held in reset, waiting for a request
// CRST  | core reset held for RST_CYCLES after accept
// RUN   | core running, watchdog counting
// RESP  | response presented until rsp_ready
module aes_sched
    import aes_sched_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AES_W-1:0] req0_din,
    input  logic [AES_W-1:0] req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AES_W-1:0] req1_din,
    input  logic [AES_W-1:0] req1_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [AES_W-1:0] rsp_dout,
    output logic             core_rst,
    output logic [AES_W-1:0] core_din,
    output logic [AES_W-1:0] core_keyin,
    input  logic [AES_W-1:0] core_dout,
    input  logic             core_done,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_CRST = 2'(ST_CRST);
    localparam logic [1:0] S_RUN  = 2'(ST_RUN);
    localparam logic [1:0] S_RESP = 2'(ST_RESP);

    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             last;
    logic [1:0]       grant;
    logic             winner;
    logic             accept;
    logic [RST_W-1:0] rcnt;
    logic [TO_W-1:0]  tcnt;

    rr_arb2 u_arb (
        .valid  ({req1_valid, req0_valid}),
        .last   (last),
        .grant  (grant),
        .winner (winner)
    );

    // Gated by rst so no handshake is advertised while the flops are held.
    assign req0_ready = !rst && (state == S_IDLE) && grant[0];
    assign req1_ready = !rst && (state == S_IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_CRST;
            S_CRST: if (rcnt == '0) state_nx = S_RUN;
            S_RUN:  if (core_done || (tcnt == TO_LAST)) state_nx = S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_dout   <= '0;
            core_rst   <= 1'b1;
            core_din   <= '0;
            core_keyin <= '0;
            rcnt       <= '0;
            tcnt       <= '0;
        end else begin
            state    <= state_nx;
            // Registered from the next state so the core reset never glitches.
            core_rst <= (state_nx != S_RUN);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        core_din   <= winner ? req1_din : req0_din;
                        core_keyin <= winner ? req1_key : req0_key;
                        rsp_id     <= winner;
                        last       <= winner;
                        rcnt       <= RST_LOAD;
                    end
                end
                S_CRST: begin
                    if (rcnt != '0) begin
                        rcnt <= rcnt - RST_W'(1);
                    end else begin
                        tcnt <= '0;
                    end
                end
                S_RUN: begin
                    // Done takes priority over a coincident timeout.
                    if (core_done) begin
                        rsp_dout <= core_dout;
                        rsp_err  <= 1'b0;
                    end else if (tcnt == TO_LAST) begin
                        rsp_dout <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
